// File: rtl/nms_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nms_scan_ctrl
// Description : Frame sequencer for the non-maximum-suppression unit. Raster
//               scans a three-row-banked magnitude/angle frame and feeds the
//               NMS unit one 3-pixel column per cycle. It then drops the
//               unit's two warm-up samples and writes W pixels per row.
// Revision    : 1.0 - initial release
// ============================================================================
module nms_scan_ctrl #(
    parameter int IMG_WIDTH  = 960,
    parameter int IMG_HEIGHT = 720,
    parameter int BIT_LENGTH = 5,
    parameter int ADDR_W     = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en0,
    output logic                  rd_en1,
    output logic                  rd_en2,
    output logic [ADDR_W-1:0]     rd_addr0,
    output logic [ADDR_W-1:0]     rd_addr1,
    output logic [ADDR_W-1:0]     rd_addr2,
    input  logic [BIT_LENGTH+1:0] rd_data0,
    input  logic [BIT_LENGTH+1:0] rd_data1,
    input  logic [BIT_LENGTH+1:0] rd_data2,
    output logic                  nm_enable,
    output logic                  nm_clear,
    output logic [1:0]            nm_angle,
    output logic [BIT_LENGTH-1:0] nm_pix0,
    output logic [BIT_LENGTH-1:0] nm_pix1,
    output logic [BIT_LENGTH-1:0] nm_pix2,
    input  logic [BIT_LENGTH-1:0] nm_pixel_out,
    input  logic                  nm_readable,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [BIT_LENGTH-1:0] wr_data
);

    // Column counter must reach W+2 (sample count saturates there).
    localparam int CNT_W = $clog2(IMG_WIDTH + 3);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CNT_W-1:0]  K_LAST   = CNT_W'(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0]  K_RD_END = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0]  SMP_END  = CNT_W'(IMG_WIDTH + 2);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       smp_q, smp_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   v0_q, v1_q, v2_q;
    logic [1:0]             ang_q, ang_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [BIT_LENGTH-1:0]  wr_data_q, wr_data_d;
    logic                   rd_go;
    logic                   unused_angle_bits;

    // Angles of the outer rows are not needed: NMS takes the centre angle.
    assign unused_angle_bits = ^{rd_data0[BIT_LENGTH+1:BIT_LENGTH],
                                 rd_data2[BIT_LENGTH+1:BIT_LENGTH]};

    // Frame sequencing: next state, column/row counters and status flags.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        base_d  = base_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    base_d  = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                k_d     = '0;
            end
            S_FEED: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (k_q == CNT_W'(1)) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_CLEAR;
                        row_d   = row_q + ROW_W'(1);
                        base_d  = base_q + W_A;
                    end
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                // The row's last write is on the bus now; done follows it.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read strobes/addresses; outer rows are suppressed at the frame edges.
    always_comb begin
        rd_go    = (state_q == S_FEED) && (k_q < K_RD_END);
        rd_en0   = rd_go && (row_q != '0);
        rd_en1   = rd_go;
        rd_en2   = rd_go && (row_q != ROW_LAST);
        rd_addr0 = rd_en0 ? (base_q - W_A + ADDR_W'(k_q)) : '0;
        rd_addr1 = rd_en1 ? (base_q + ADDR_W'(k_q))       : '0;
        rd_addr2 = rd_en2 ? (base_q + W_A + ADDR_W'(k_q)) : '0;
    end

    // NMS feed: pixels are zero unless a read was issued last cycle, and
    // the angle lags one column so it matches the centre of the window.
    always_comb begin
        nm_enable = (state_q == S_FEED);
        nm_clear  = (state_q == S_CLEAR);
        nm_pix0   = v0_q ? rd_data0[BIT_LENGTH-1:0] : '0;
        nm_pix1   = v1_q ? rd_data1[BIT_LENGTH-1:0] : '0;
        nm_pix2   = v2_q ? rd_data2[BIT_LENGTH-1:0] : '0;
        ang_d     = v1_q ? rd_data1[BIT_LENGTH+1:BIT_LENGTH] : 2'b00;
        nm_angle  = ang_q;
    end

    // Result collection: skip two warm-up samples, write the next W.
    always_comb begin
        smp_d     = smp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if ((state_q == S_CLEAR) || (state_q == S_IDLE)) begin
            smp_d = '0;
        end else if (nm_readable && (smp_q < SMP_END)) begin
            smp_d = smp_q + CNT_W'(1);
            if (smp_q >= CNT_W'(2)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_W'(smp_q) - ADDR_W'(2);
                wr_data_d = nm_pixel_out;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            smp_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            ang_q     <= 2'b00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            smp_q     <= smp_d;
            row_q     <= row_d;
            base_q    <= base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            v0_q      <= rd_en0;
            v1_q      <= rd_en1;
            v2_q      <= rd_en2;
            ang_q     <= ang_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_nms_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nms_scan_ctrl
// Description : Self-checking bench for nms_scan_ctrl (W=4, H=3) with a
//               behavioural NMS unit, a frame memory and a second H=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nms_scan_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int BL   = 5;
    localparam int AW   = 8;
    localparam int NPIX = W * H;
    localparam int ROWP = W + 5;
    localparam int W1   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    logic busy, done, rd_en0, rd_en1, rd_en2, nm_enable, nm_clear, wr_en;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, wr_addr;
    logic [BL+1:0] rd_data0, rd_data1, rd_data2;
    logic [1:0]    nm_angle;
    logic [BL-1:0] nm_pix0, nm_pix1, nm_pix2, nm_pixel_out, wr_data;
    logic          nm_readable;

    logic busy_b, done_b, rd_en0_b, rd_en1_b, rd_en2_b, nm_enable_b, nm_clear_b, wr_en_b;
    logic [AW-1:0] rd_addr0_b, rd_addr1_b, rd_addr2_b, wr_addr_b;
    logic [BL+1:0] rd_data0_b, rd_data1_b, rd_data2_b;
    logic [1:0]    nm_angle_b;
    logic [BL-1:0] nm_pix0_b, nm_pix1_b, nm_pix2_b, wr_data_b;
    logic          nm_readable_b, d1_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nms_scan_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_LENGTH(BL), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .nm_enable(nm_enable), .nm_clear(nm_clear), .nm_angle(nm_angle),
        .nm_pix0(nm_pix0), .nm_pix1(nm_pix1), .nm_pix2(nm_pix2),
        .nm_pixel_out(nm_pixel_out), .nm_readable(nm_readable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    nms_scan_ctrl #(.IMG_WIDTH(W1), .IMG_HEIGHT(1), .BIT_LENGTH(BL), .ADDR_W(AW)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en0(rd_en0_b), .rd_en1(rd_en1_b), .rd_en2(rd_en2_b),
        .rd_addr0(rd_addr0_b), .rd_addr1(rd_addr1_b), .rd_addr2(rd_addr2_b),
        .rd_data0(rd_data0_b), .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
        .nm_enable(nm_enable_b), .nm_clear(nm_clear_b), .nm_angle(nm_angle_b),
        .nm_pix0(nm_pix0_b), .nm_pix1(nm_pix1_b), .nm_pix2(nm_pix2_b),
        .nm_pixel_out(5'd9), .nm_readable(nm_readable_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    // ---------------- frame memory (one-cycle read latency) ----------------
    logic [BL-1:0] mag [0:NPIX-1];
    logic [1:0]    ang [0:NPIX-1];

    always @(posedge clk) begin
        rd_data0 <= rd_en0 ? {ang[int'(rd_addr0)], mag[int'(rd_addr0)]} : 7'($urandom);
        rd_data1 <= rd_en1 ? {ang[int'(rd_addr1)], mag[int'(rd_addr1)]} : 7'($urandom);
        rd_data2 <= rd_en2 ? {ang[int'(rd_addr2)], mag[int'(rd_addr2)]} : 7'($urandom);
        rd_data0_b <= 7'($urandom);
        rd_data1_b <= 7'($urandom);
        rd_data2_b <= 7'($urandom);
    end

    // ---------------- behavioural NMS unit, 2-cycle latency ----------------
    // Columns are packed {top, centre, bottom}.
    function automatic logic [BL-1:0] stub_fn(input logic [14:0] l, input logic [14:0] c,
                                              input logic [14:0] r, input logic [1:0] a);
        logic [BL-1:0] m, n1, n2;
        m = c[9:5];
        case (a)
            2'd0:    begin n1 = l[9:5];   n2 = r[9:5];   end
            2'd1:    begin n1 = l[4:0];   n2 = r[14:10]; end
            2'd2:    begin n1 = c[14:10]; n2 = c[4:0];   end
            default: begin n1 = l[14:10]; n2 = r[4:0];   end
        endcase
        return (m >= n1 && m >= n2) ? m : '0;
    endfunction

    logic          nms_arst, nms_arst_b, s1_vld;
    logic [14:0]   win_c, win_r;
    logic [BL-1:0] s1_val;
    assign nms_arst   = reset | nm_clear;
    assign nms_arst_b = reset | nm_clear_b;

    always @(posedge clk or posedge nms_arst) begin
        if (nms_arst) begin
            win_c <= '0; win_r <= '0; s1_vld <= 1'b0; s1_val <= '0;
            nm_readable <= 1'b0; nm_pixel_out <= '0;
        end else begin
            s1_vld       <= nm_enable;
            nm_readable  <= s1_vld;
            nm_pixel_out <= s1_val;
            if (nm_enable) begin
                win_c  <= win_r;
                win_r  <= {nm_pix0, nm_pix1, nm_pix2};
                s1_val <= stub_fn(win_c, win_r, {nm_pix0, nm_pix1, nm_pix2}, nm_angle);
            end
        end
    end

    always @(posedge clk or posedge nms_arst_b) begin
        if (nms_arst_b) begin
            d1_b <= 1'b0; nm_readable_b <= 1'b0;
        end else begin
            d1_b <= nm_enable_b; nm_readable_b <= d1_b;
        end
    end

    // ---------------- reference: NMS over the whole frame ----------------
    function automatic int pix(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return int'(mag[r*W + c]);
    endfunction

    function automatic int ref_px(input int r, input int c);
        int m, n1, n2;
        m = pix(r, c);
        case (int'(ang[r*W + c]))
            0:       begin n1 = pix(r, c-1);   n2 = pix(r, c+1);   end
            1:       begin n1 = pix(r+1, c-1); n2 = pix(r-1, c+1); end
            2:       begin n1 = pix(r-1, c);   n2 = pix(r+1, c);   end
            default: begin n1 = pix(r-1, c-1); n2 = pix(r+1, c+1); end
        endcase
        return (m >= n1 && m >= n2) ? m : 0;
    endfunction

    // ---------------- output monitors ----------------
    int obs_cyc[$], obs_addr[$], obs_data[$];
    int done_cnt = 0, done_rel = -1, rd_viol = 0, t0 = 0;
    logic [BL-1:0] out_mem [0:NPIX-1];
    int obs_b_cyc[$], obs_b_addr[$], obs_b_data[$];
    int done_cnt_b = 0, done_rel_b = -1, edge_rd_b = 0, t0_b = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_cyc.push_back(cyc - t0);
            obs_addr.push_back(int'(wr_addr));
            obs_data.push_back(int'(wr_data));
            if (int'(wr_addr) < NPIX) out_mem[int'(wr_addr)] <= wr_data;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_rel <= cyc - t0;
        end
        if ((rd_en0 && int'(rd_addr0) >= NPIX) || (rd_en1 && int'(rd_addr1) >= NPIX) ||
            (rd_en2 && int'(rd_addr2) >= NPIX))
            rd_viol <= rd_viol + 1;
        if (wr_en_b) begin
            obs_b_cyc.push_back(cyc - t0_b);
            obs_b_addr.push_back(int'(wr_addr_b));
            obs_b_data.push_back(int'(wr_data_b));
        end
        if (done_b) begin
            done_cnt_b <= done_cnt_b + 1;
            done_rel_b <= cyc - t0_b;
        end
        if (rd_en0_b || rd_en2_b) edge_rd_b <= edge_rd_b + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int m, input int a);
        for (int i = 0; i < NPIX; i++) begin
            mag[i] = BL'(m);
            ang[i] = 2'(a);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) begin
            mag[i] = BL'($urandom_range(0, 31));
            ang[i] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic run_frame(input string tag, input int restart_at);
        int wbase, dbase, n;
        wbase = obs_addr.size();
        dbase = done_cnt;
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy_c1"}, 32'(busy), 1);
        chk({tag, "_clear_c1"}, 32'({nm_clear, nm_enable}), 32'b10);
        for (int i = 0; i < 400 && done_cnt == dbase; i++) begin
            start = ((cyc - t0) == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt - dbase), 1);
        chk({tag, "_done_cycle"}, 32'(done_rel), 32'(7 + (H-1)*ROWP + W));
        chk({tag, "_busy_end"}, 32'(busy), 0);
        n = obs_addr.size() - wbase;
        chk({tag, "_nwrites"}, 32'(n), 32'(NPIX));
        for (int j = 0; j < NPIX && j < n; j++) begin
            chk($sformatf("%s_wr%0d_addr", tag, j), 32'(obs_addr[wbase+j]), 32'(j));
            chk($sformatf("%s_wr%0d_data", tag, j), 32'(obs_data[wbase+j]), 32'(ref_px(j/W, j%W)));
            chk($sformatf("%s_wr%0d_cyc", tag, j), 32'(obs_cyc[wbase+j]),
                32'(7 + (j/W)*ROWP + (j%W)));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wb, db;
        fill(0, 0);
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({busy, done, rd_en0, rd_en1, rd_en2, nm_enable, nm_clear, wr_en}), 0);
        chk("reset_data", 32'({nm_angle, nm_pix0, nm_pix1, nm_pix2, wr_data}), 0);
        chk("reset_addr", 32'(rd_addr0 | rd_addr1 | rd_addr2 | wr_addr), 0);
        chk("reset_dut1", 32'({busy_b, done_b, wr_en_b, nm_enable_b, nm_clear_b}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Uniform frame; a second start mid-frame must be ignored.
        fill(5, 0);
        run_frame("allfive", 12);
        chk("allfive_addr0", 32'(out_mem[0]), 5);
        chk("allfive_addr11", 32'(out_mem[11]), 5);

        // Horizontal suppression on row 1.
        fill(0, 0);
        mag[4] = 5'd1; mag[5] = 5'd3; mag[6] = 5'd2; mag[7] = 5'd0;
        run_frame("row1", -1);
        chk("row1_addr4", 32'(out_mem[4]), 0);
        chk("row1_addr5", 32'(out_mem[5]), 3);
        chk("row1_addr6", 32'(out_mem[6]), 0);

        // Vertical suppression including the zero border below row H-1.
        fill(0, 2);
        mag[2] = 5'd2; mag[6] = 5'd4; mag[10] = 5'd6;
        run_frame("vert", -1);
        chk("vert_addr6", 32'(out_mem[6]), 0);
        chk("vert_addr2", 32'(out_mem[2]), 0);
        chk("vert_addr10", 32'(out_mem[10]), 6);

        // Diagonals.
        fill(0, 0);
        mag[5] = 5'd3; ang[5] = 2'd1; mag[8] = 5'd7;
        run_frame("diag45", -1);
        chk("diag45_addr5", 32'(out_mem[5]), 0);
        fill(0, 0);
        mag[5] = 5'd3; ang[5] = 2'd3; mag[0] = 5'd1; mag[10] = 5'd1;
        run_frame("diag135", -1);
        chk("diag135_addr5", 32'(out_mem[5]), 3);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame($sformatf("rand%0d", f), -1);
        end

        // Reset mid-frame: outputs clear, no further writes, no done.
        fill_random();
        wb = obs_addr.size();
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        while ((cyc - t0) < 14) @(negedge clk);
        reset = 1'b1;
        db = done_cnt;
        @(negedge clk);
        chk("midrst_ctrl", 32'({busy, done, rd_en0, rd_en1, rd_en2, nm_enable, nm_clear, wr_en}), 0);
        chk("midrst_data", 32'({nm_angle, nm_pix0, nm_pix1, nm_pix2, wr_data}), 0);
        chk("midrst_addr", 32'(rd_addr0 | rd_addr1 | rd_addr2 | wr_addr), 0);
        chk("midrst_row0_writes", 32'(obs_addr.size() - wb), 32'(W));
        wb = obs_addr.size();
        @(negedge clk); reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_writes", 32'(obs_addr.size() - wb), 0);
        chk("midrst_no_done", 32'(done_cnt - db), 0);
        fill_random();
        run_frame("after_rst", -1);
        chk("read_range", 32'(rd_viol), 0);

        // Single-row instance: no outer-row reads, W writes, done.
        @(negedge clk); start_b = 1'b1; t0_b = cyc;
        @(negedge clk); start_b = 1'b0;
        chk("h1_busy_c1", 32'(busy_b), 1);
        for (int i = 0; i < 100 && done_cnt_b == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("h1_done_count", 32'(done_cnt_b), 1);
        chk("h1_done_cycle", 32'(done_rel_b), 32'(7 + W1));
        chk("h1_outer_reads", 32'(edge_rd_b), 0);
        chk("h1_nwrites", 32'(obs_b_addr.size()), 32'(W1));
        for (int j = 0; j < W1 && j < obs_b_addr.size(); j++) begin
            chk($sformatf("h1_wr%0d_addr", j), 32'(obs_b_addr[j]), 32'(j));
            chk($sformatf("h1_wr%0d_data", j), 32'(obs_b_data[j]), 9);
            chk($sformatf("h1_wr%0d_cyc", j), 32'(obs_b_cyc[j]), 32'(7 + j));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation ceiling reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
